// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared geometry constants, FSM states and operand-vector type
package operand_fetch_pkg;
    localparam int LANES      = 16;
    localparam int DATA_W     = 8;
    localparam int A_DEPTH    = 4096;
    localparam int B_DEPTH    = 64;
    localparam int ROM_LAT    = 2;
    localparam int FIFO_DEPTH = ROM_LAT + 2;
    localparam int A_AW       = $clog2(A_DEPTH);
    localparam int B_AW       = $clog2(B_DEPTH);
    localparam int VEC_W      = LANES * DATA_W;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
    typedef logic [VEC_W-1:0] vec_t;
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: synchronous FIFO with occupancy count
// A write to a full FIFO lands only when a read retires the head in the same cycle.
module operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         rd_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q;
    logic             rd_en, wr_en;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign rd_en   = rd_i && cnt_q != '0;
    assign wr_en   = wr_i && (cnt_q != CW'(DEPTH) || rd_en);
    assign dout_o  = mem_q[rp_q];
    assign valid_o = cnt_q != '0;
    assign count_o = cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= inc(wp_q);
            end
            if (rd_en) rp_q <= inc(rp_q);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issues ROM A/B lane-0 addresses under credit, tags beats through the ROM
// latency and buffers returned operand pairs for a valid/ready consumer.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [A_AW-1:0] rom_a_base_o,
    output logic [B_AW-1:0] rom_b_base_o,
    output logic            rom_rd_o,
    input  vec_t            rom_a_q_i,
    input  vec_t            rom_b_q_i,
    output logic            vec_valid_o,
    input  logic            vec_ready_i,
    output vec_t            vec_a_o,
    output vec_t            vec_b_o,
    output logic            vec_last_o
);
    localparam logic [A_AW-1:0] A_STEP = A_AW'(LANES);
    localparam logic [A_AW-1:0] A_LAST = A_AW'(A_DEPTH - LANES);
    localparam logic [B_AW-1:0] B_STEP = B_AW'(LANES);
    localparam logic [B_AW-1:0] B_LAST = B_AW'(B_DEPTH - LANES);
    state_e             state_q, state_d;
    logic [A_AW-1:0]    a_q, a_d;
    logic [B_AW-1:0]    b_q, b_d;
    logic [ROM_LAT-1:0] pv_q, pl_q;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W:0]     outstanding;
    logic [2*VEC_W:0]   head;
    logic               fifo_valid, pop, last_issue;
    // Credit covers every beat already issued but not yet consumed.
    always_comb begin
        outstanding = {1'b0, fifo_cnt};
        for (int i = 0; i < ROM_LAT; i++) outstanding = outstanding + (CNT_W+1)'(pv_q[i]);
    end
    assign rom_rd_o     = state_q == FETCH && outstanding < (CNT_W+1)'(FIFO_DEPTH);
    assign last_issue   = rom_rd_o && a_q == A_LAST;
    assign pop          = fifo_valid && vec_ready_i;
    assign busy_o       = state_q == FETCH || state_q == DRAIN;
    assign done_o       = state_q == DONE;
    assign rom_a_base_o = a_q;
    assign rom_b_base_o = b_q;
    assign vec_valid_o  = fifo_valid;
    assign vec_last_o   = fifo_valid && head[2*VEC_W];
    assign vec_a_o      = head[2*VEC_W-1:VEC_W];
    assign vec_b_o      = head[VEC_W-1:0];
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d = FETCH;
                a_d     = '0;
                b_d     = '0;
            end
            FETCH: if (rom_rd_o) begin
                a_d     = a_q + A_STEP;
                b_d     = b_q == B_LAST ? '0 : b_q + B_STEP;
                state_d = last_issue ? DRAIN : FETCH;
            end
            DRAIN: state_d = pop && vec_last_o ? DONE : DRAIN;
            DONE:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pv_q    <= (pv_q << 1) | ROM_LAT'(rom_rd_o);
            pl_q    <= (pl_q << 1) | ROM_LAT'(last_issue);
        end
    end
    operand_fifo #(.WIDTH(2*VEC_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (pv_q[ROM_LAT-1]),
        .din_i   ({pl_q[ROM_LAT-1], rom_a_q_i, rom_b_q_i}),
        .rd_i    (pop),
        .dout_o  (head),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );
endmodule
